key_event_scan: RTL and testbench

Multi-channel key front end that replaces single-key debounce in the control path. Each of `NUM_KEYS` raw inputs is synchronised, debounced with a millisecond timebase generated internally from `CLK_FREQ`, and classified into press, release, long-press and auto-repeat events. Outputs are per-key levels and single-cycle event pulses consumed by the menu/parameter controller.

---
 rtl/key_event_pkg.sv | 18 +
 rtl/key_event_channel.sv | 145 ++++++++++++++
 rtl/key_event_scan.sv | 65 ++++++
 tb/tb_key_event_scan.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types and helpers for the multi-key event front end.
package key_event_pkg;

    // Per-channel debounce/classification state.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Bits needed to hold 0..max_val; never less than one bit so that
    // disabled features (e.g. a zero repeat period) still elaborate.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_event_channel.sv
// One key channel: two-flop synchroniser, debounce FSM and the hold /
// auto-repeat counters that turn a key level into single-cycle events.
module key_event_channel
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_MS        = 20,
    parameter int LONG_MS            = 1000,
    parameter int REPEAT_MS          = 200,
    parameter bit KEY_RELEASED_VALUE = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic key_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = cnt_width(DEBOUNCE_MS);
    localparam int HOLD_W = cnt_width(LONG_MS);
    localparam int REP_W  = cnt_width(REPEAT_MS);

    localparam logic [DB_W-1:0]   DB_LOAD  = DB_W'(DEBOUNCE_MS);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_MS);
    localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

    logic              sync_meta;
    logic              sync_out;
    logic              active;
    key_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [REP_W-1:0]  rep_next;

    // Bring the asynchronous key level into the clk domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= KEY_RELEASED_VALUE;
            sync_out  <= KEY_RELEASED_VALUE;
        end else begin
            // NOTE: non-blocking so sync_out takes the previous sync_meta,
            // which is what makes this a genuine two-stage chain.
            sync_meta <= key_in;
            sync_out  <= sync_meta;
        end
    end

    assign active    = (sync_out != KEY_RELEASED_VALUE);
    assign hold_next = hold_cnt + HOLD_ONE;
    assign rep_next  = rep_cnt + REP_ONE;

    // Debounce FSM with hold/repeat counting; all outputs are registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (active) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DB_LOAD;
                    end
                end

                PRESS_WAIT: begin
                    // A level change wins over a coincident tick.
                    if (!active) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (db_cnt == DB_ONE) begin
                            state       <= HELD;
                            pressed     <= 1'b1;
                            press_pulse <= 1'b1;
                            hold_cnt    <= '0;
                            rep_cnt     <= '0;
                        end else begin
                            db_cnt <= db_cnt - DB_ONE;
                        end
                    end
                end

                HELD: begin
                    if (!active) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= DB_LOAD;
                    end else if (tick) begin
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_next;
                            if (hold_next == HOLD_MAX) begin
                                long_pulse <= 1'b1;
                            end
                        end else if (REPEAT_MS != 0) begin
                            if (rep_next == REP_MAX) begin
                                repeat_pulse <= 1'b1;
                                rep_cnt      <= '0;
                            end else begin
                                rep_cnt <= rep_next;
                            end
                        end
                    end
                end

                RELEASE_WAIT: begin
                    // Hold and repeat counters are frozen here so a short
                    // glitch only delays the long press, never restarts it.
                    if (active) begin
                        state <= HELD;
                    end else if (tick) begin
                        if (db_cnt == DB_ONE) begin
                            state         <= IDLE;
                            pressed       <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt - DB_ONE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_event_scan.sv
// Multi-key front end: shared millisecond tick plus one event channel per key.
module key_event_scan
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS           = 4,
    parameter int CLK_FREQ           = 50_000_000,
    parameter int DEBOUNCE_MS        = 20,
    parameter int LONG_MS            = 1000,
    parameter int REPEAT_MS          = 200,
    parameter bit KEY_RELEASED_VALUE = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic                any_pressed
);

    localparam int DIV   = CLK_FREQ / 1000;
    localparam int DIV_W = cnt_width(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    // Millisecond divider: counts 0..DIV-1, tick on the terminal count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_event_channel #(
            .DEBOUNCE_MS        (DEBOUNCE_MS),
            .LONG_MS            (LONG_MS),
            .REPEAT_MS          (REPEAT_MS),
            .KEY_RELEASED_VALUE (KEY_RELEASED_VALUE)
        ) u_channel (
            .clk           (clk),
            .resetn        (resetn),
            .tick          (tick),
            .key_in        (key_in[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    assign any_pressed = |pressed;

endmodule

// File: tb/tb_key_event_scan.sv
// Directed bench for key_event_scan with a cycle-accurate behavioural model.
// The model works from "ticks of stable input since the last level change"
// and "ticks held", deriving long/repeat events arithmetically.
module tb_key_event_scan;

    localparam int  NK       = 4;
    localparam int  CLK_FREQ = 10_000;
    localparam int  DEB      = 20;
    localparam int  LONG     = 100;
    localparam int  REP      = 50;
    localparam int  CPM      = CLK_FREQ / 1000;
    localparam bit  KRV      = 1'b1;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic          any_pressed;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_event_scan #(
        .NUM_KEYS           (NK),
        .CLK_FREQ           (CLK_FREQ),
        .DEBOUNCE_MS        (DEB),
        .LONG_MS            (LONG),
        .REPEAT_MS          (REP),
        .KEY_RELEASED_VALUE (KRV)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .key_in        (key_in),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .any_pressed   (any_pressed)
    );

    // ---------------- behavioural model ----------------
    int            cyc = 0;            // clock edges since reset release
    logic [NK-1:0] key_d1 = '1;        // key level one edge ago
    logic [NK-1:0] key_d2 = '1;        // key level two edges ago
    logic [NK-1:0] act_prev = '0;
    logic [NK-1:0] deb = '0;
    int            stable_ticks [NK];
    int            hold_ticks   [NK];
    logic [NK-1:0] exp_press = '0, exp_release = '0, exp_long = '0, exp_repeat = '0;

    int press_cyc [NK], release_cyc [NK], long_cyc [NK], first_rep_cyc [NK];
    int press_cnt [NK], release_cnt [NK], long_cnt [NK], rep_cnt [NK];

    task automatic model_step();
        logic [NK-1:0] act;
        bit            tick_now;
        exp_press   = '0;
        exp_release = '0;
        exp_long    = '0;
        exp_repeat  = '0;
        if (!resetn) begin
            cyc      = 0;
            key_d1   = '1;
            key_d2   = '1;
            act_prev = '0;
            deb      = '0;
            for (int i = 0; i < NK; i++) begin
                stable_ticks[i] = 0;
                hold_ticks[i]   = 0;
            end
            return;
        end
        cyc++;
        tick_now = (cyc % CPM == 0);
        for (int i = 0; i < NK; i++) act[i] = (key_d2[i] != KRV);
        key_d2 = key_d1;
        key_d1 = key_in;
        for (int i = 0; i < NK; i++) begin
            if (act[i] != act_prev[i]) begin
                stable_ticks[i] = 0;
            end else if (act[i] != deb[i]) begin
                if (tick_now) begin
                    stable_ticks[i]++;
                    if (stable_ticks[i] == DEB) begin
                        deb[i] = act[i];
                        hold_ticks[i] = 0;
                        if (act[i]) begin
                            exp_press[i] = 1'b1;
                            press_cyc[i] = cyc;
                            press_cnt[i]++;
                        end else begin
                            exp_release[i] = 1'b1;
                            release_cyc[i] = cyc;
                            release_cnt[i]++;
                        end
                    end
                end
            end else if (deb[i] && tick_now) begin
                hold_ticks[i]++;
                if (hold_ticks[i] == LONG) begin
                    exp_long[i] = 1'b1;
                    long_cyc[i] = cyc;
                    long_cnt[i]++;
                end else if (hold_ticks[i] > LONG && (hold_ticks[i] - LONG) % REP == 0) begin
                    exp_repeat[i] = 1'b1;
                    if (first_rep_cyc[i] < 0) first_rep_cyc[i] = cyc;
                    rep_cnt[i]++;
                end
            end
            act_prev[i] = act[i];
        end
    endtask

    initial begin
        for (int i = 0; i < NK; i++) begin
            press_cyc[i] = -1; release_cyc[i] = -1; long_cyc[i] = -1; first_rep_cyc[i] = -1;
            press_cnt[i] = 0;  release_cnt[i] = 0;  long_cnt[i] = 0;  rep_cnt[i] = 0;
            stable_ticks[i] = 0; hold_ticks[i] = 0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [5*NK:0] got, expv;
        forever begin
            @(negedge clk);
            got = {pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed};
            if (!resetn) expv = '0;
            else expv = {deb, exp_press, exp_release, exp_long, exp_repeat, |deb};
            checks++;
            if (got !== expv) begin
                failures++;
                if (failures <= 30)
                    $display("FAIL cycle_compare cyc=%0d got=%h expected=%h", cyc, got, expv);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Advance to 2 time units after clock edge number n.
    task automatic run_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        resetn = 1'b0;
        key_in = '1;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        // Clean press of key0 for 60 ms.
        run_to(5);    key_in[0] = 1'b0;
        run_to(605);  key_in[0] = 1'b1;
        run_to(810);
        check("t1_press_cycle",   press_cyc[0],   200);
        check("t1_release_cycle", release_cyc[0], 800);
        check("t1_no_long",       long_cnt[0],    0);

        // Bouncing key1, never stable for a full debounce window.
        run_to(1000); key_in[1] = 1'b0;
        run_to(1030); key_in[1] = 1'b1;
        run_to(1060); key_in[1] = 1'b0;
        run_to(1090); key_in[1] = 1'b1;
        run_to(1120); key_in[1] = 1'b0;
        run_to(1150); key_in[1] = 1'b1;
        run_to(1400);
        check("t2_no_press",   press_cnt[1],   0);
        check("t2_no_release", release_cnt[1], 0);

        // Key2 held 300 ms: long press then three repeats.
        run_to(2005); key_in[2] = 1'b0;
        run_to(5005); key_in[2] = 1'b1;
        run_to(5300);
        check("t3_press_cycle",   press_cyc[2],     2200);
        check("t3_long_cycle",    long_cyc[2],      3200);
        check("t3_first_repeat",  first_rep_cyc[2], 3700);
        check("t3_repeat_count",  rep_cnt[2],       3);
        check("t3_release_cycle", release_cyc[2],   5200);
        check("t3_release_count", release_cnt[2],   1);

        // Key3 glitch of 5 ms during hold.
        run_to(6005); key_in[3] = 1'b0;
        run_to(6505); key_in[3] = 1'b1;
        run_to(6555); key_in[3] = 1'b0;
        run_to(6600);
        check("t4_pressed_kept",  pressed[3],     1);
        check("t4_no_release",    release_cnt[3], 0);
        run_to(7305); key_in[3] = 1'b1;
        run_to(7550);
        check("t4_long_delayed",  long_cyc[3],    7250);
        check("t4_release_cycle", release_cyc[3], 7500);
        check("t4_release_count", release_cnt[3], 1);

        // Keys 0 and 3 pressed in the same cycle.
        run_to(8005); key_in[0] = 1'b0; key_in[3] = 1'b0;
        run_to(8405); key_in[0] = 1'b1;
        check("t5_press_k0", press_cyc[0], 8200);
        check("t5_press_k3", press_cyc[3], 8200);
        run_to(8505); key_in[3] = 1'b1;
        run_to(8650);
        check("t5_any_one_held", any_pressed, 1);
        run_to(8710);
        check("t5_any_released", any_pressed, 0);
        check("t5_release_k0", release_cyc[0], 8600);
        check("t5_release_k3", release_cyc[3], 8700);

        // Reset while key0 is held.
        run_to(9005); key_in[0] = 1'b0;
        run_to(9305);
        check("t6_held_before_reset", pressed[0], 1);
        resetn = 1'b0;
        #1;
        check("t6_outputs_cleared",
              {11'd0, pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed}, 0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        run_to(205);
        check("t6_repress_cycle",     press_cyc[0],   200);
        check("t6_no_reset_release",  release_cnt[0], 2);
        key_in[0] = 1'b1;
        run_to(420);
        check("t6_release_cycle", release_cyc[0], 400);
        check("t6_release_count", release_cnt[0], 3);
        check("t6_no_long_k0",    long_cnt[0],    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
